// File: rtl/vol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vol_pkg
//  Description : Shared constants, types and helpers for the volume control
//                block: attenuation level width/range, the SCI_VOL step and
//                the handshake FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package vol_pkg;

    localparam int              LEVEL_W   = 4;
    localparam logic [3:0]      MAX_LEVEL = 4'd15;
    // One attenuation step moves both channel bytes of SCI_VOL by 0x10.
    localparam logic [15:0]     VOL_STEP  = 16'h1010;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } hs_state_t;

    // L * 0x1010 == {L,4'h0,L,4'h0}: left and right channels equal.
    function automatic logic [15:0] level_to_vol(input level_t l);
        return VOL_STEP * {{(16-LEVEL_W){1'b0}}, l};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One push button: 2-flop synchronizer, stability debounce and
//                step-event generation (press edge, hold delay, auto-repeat).
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock, rising edge
//    rst_n    in   asynchronous active-low reset
//    btn_raw  in   raw asynchronous button, active-high
//    clr      in   suppress steps and clear the repeat timer
//    level    out  debounced button level
//    step     out  single-cycle step event
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYC  = 250000,
    parameter int HOLD_CYC = 6250000,
    parameter int REP_CYC  = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic clr,
    output logic level,
    output logic step
);

    localparam int MAX_A   = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_A > REP_CYC) ? MAX_A : REP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic [CNT_W-1:0] rep_target;
    logic             rise;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;

        // Any cycle where the synchronized level agrees restarts the count.
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == CNT_W'(DEB_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        prev_d = deb_q;
        rise   = deb_q & ~prev_q;

        // rep_cnt_q counts cycles since the last step; zero means disarmed,
        // so a clear while held stops repeats until the next press.
        rep_target  = rep_phase_q ? CNT_W'(REP_CYC) : CNT_W'(HOLD_CYC);
        step        = 1'b0;
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        if (!deb_q || clr) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (rise) begin
            step        = 1'b1;
            rep_cnt_d   = CNT_W'(1);
            rep_phase_d = 1'b0;
        end else if (rep_cnt_q != '0) begin
            if (rep_cnt_q == rep_target) begin
                step        = 1'b1;
                rep_cnt_d   = CNT_W'(1);
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            prev_q      <= 1'b0;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            prev_q      <= prev_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign level = deb_q;

endmodule
`default_nettype wire

// File: rtl/vol_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : vol_adjust
//  Description : Two-button volume control for a VS1003. Keeps a 4-bit
//                attenuation level, presents it as an SCI_VOL word and
//                requests an SCI write whenever the level changes.
//  Revision    : 1.0  initial release
//
//  Ports
//    CLK       in   clock, rising edge
//    RSTn      in   asynchronous active-low reset
//    btn_up    in   raw button, louder (level - 1)
//    btn_down  in   raw button, quieter (level + 1)
//    vol       out  SCI_VOL word {L,4'h0,L,4'h0}
//    vol_req   out  write request, held until acknowledged
//    vol_ack   in   single-cycle acknowledge from the SCI writer
// ============================================================================
module vol_adjust
    import vol_pkg::*;
#(
    parameter int DEB_CYC    = 250000,
    parameter int HOLD_CYC   = 6250000,
    parameter int REP_CYC    = 2500000,
    parameter int INIT_LEVEL = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [15:0] vol,
    output logic        vol_req,
    input  logic        vol_ack
);

    localparam level_t INIT_L = level_t'(INIT_LEVEL);

    logic        up_level, down_level;
    logic        up_step, down_step;
    logic        both_held;
    level_t      level_q, level_d;
    logic [15:0] vol_q, vol_d;
    hs_state_t   state_q, state_d;

    assign both_held = up_level & down_level;

    btn_debounce #(
        .DEB_CYC (DEB_CYC),
        .HOLD_CYC(HOLD_CYC),
        .REP_CYC (REP_CYC)
    ) u_up (
        .clk    (CLK),
        .rst_n  (RSTn),
        .btn_raw(btn_up),
        .clr    (both_held),
        .level  (up_level),
        .step   (up_step)
    );

    btn_debounce #(
        .DEB_CYC (DEB_CYC),
        .HOLD_CYC(HOLD_CYC),
        .REP_CYC (REP_CYC)
    ) u_down (
        .clk    (CLK),
        .rst_n  (RSTn),
        .btn_raw(btn_down),
        .clr    (both_held),
        .level  (down_level),
        .step   (down_step)
    );

    always_comb begin
        level_d = level_q;
        if (up_step && !down_step) begin
            if (level_q != '0) level_d = level_q - 4'd1;
        end else if (down_step && !up_step) begin
            if (level_q != MAX_LEVEL) level_d = level_q + 4'd1;
        end

        vol_d = level_to_vol(level_d);

        // A saturated step leaves level_d == level_q and raises nothing;
        // a real change always (re)enters PEND, even alongside an ack.
        state_d = state_q;
        if (level_d != level_q) begin
            state_d = ST_PEND;
        end else if (state_q == ST_PEND && vol_ack) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            level_q <= INIT_L;
            vol_q   <= level_to_vol(INIT_L);
            state_q <= ST_PEND;
        end else begin
            level_q <= level_d;
            vol_q   <= vol_d;
            state_q <= state_d;
        end
    end

    assign vol     = vol_q;
    assign vol_req = (state_q == ST_PEND);

endmodule
`default_nettype wire

// File: tb/tb_vol_adjust.sv
`timescale 1ns/1ps
module tb_vol_adjust;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int INIT = 4;

    logic        CLK      = 1'b0;
    logic        RSTn     = 1'b1;
    logic        btn_up   = 1'b0;
    logic        btn_down = 1'b0;
    logic        vol_ack  = 1'b0;
    logic [15:0] vol;
    logic        vol_req;

    int checks = 0;
    int errors = 0;

    vol_adjust #(
        .DEB_CYC   (DEB),
        .HOLD_CYC  (HOLD),
        .REP_CYC   (REP),
        .INIT_LEVEL(INIT)
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .vol     (vol),
        .vol_req (vol_req),
        .vol_ack (vol_ack)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // Per button: the two synchronizer stages, the debounced level, how many
    // consecutive cycles the synchronized level has disagreed, how long the
    // debounced level has been high, and whether repeats are still allowed.
    typedef struct packed {
        logic s1;
        logic s2;
        logic deb;
        int   dcnt;
        int   age;
        logic armed;
    } btn_m_t;

    btn_m_t      mu, md;
    int          mlvl;
    logic        mpend;
    logic        m_both, m_fu, m_fd;
    int          m_lvl_n;
    logic [15:0] exp_vol;

    // Step when just pressed, after HOLD cycles held, then every REP cycles.
    function automatic logic fires(input btn_m_t b, input logic both);
        if (!b.armed || both) return 1'b0;
        if (b.age == 0 || b.age == HOLD) return 1'b1;
        return (b.age > HOLD) && (((b.age - HOLD) % REP) == 0);
    endfunction

    function automatic btn_m_t btn_next(input btn_m_t b, input logic raw, input logic both);
        btn_m_t n;
        n    = b;
        n.s1 = raw;
        n.s2 = b.s1;
        if (b.s2 != b.deb) begin
            n.dcnt = b.dcnt + 1;
            if (n.dcnt == DEB) begin
                n.deb  = b.s2;
                n.dcnt = 0;
            end
        end else begin
            n.dcnt = 0;
        end
        if (both) n.armed = 1'b0;
        if (n.deb && !b.deb) begin
            n.age   = 0;
            n.armed = 1'b1;
        end else if (!n.deb) begin
            n.age   = 0;
            n.armed = 1'b0;
        end else begin
            n.age = b.age + 1;
        end
        return n;
    endfunction

    always_comb begin
        m_both  = mu.deb & md.deb;
        m_fu    = fires(mu, m_both);
        m_fd    = fires(md, m_both);
        m_lvl_n = mlvl;
        if (m_fu) m_lvl_n = (mlvl > 0) ? mlvl - 1 : 0;
        if (m_fd) m_lvl_n = (mlvl < 15) ? mlvl + 1 : 15;
        exp_vol = 16'(mlvl * 32'h1010);
    end

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mu    <= '0;
            md    <= '0;
            mlvl  <= INIT;
            mpend <= 1'b1;
        end else begin
            mu    <= btn_next(mu, btn_up, m_both);
            md    <= btn_next(md, btn_down, m_both);
            mlvl  <= m_lvl_n;
            mpend <= (m_lvl_n != mlvl) ? 1'b1 : (vol_ack ? 1'b0 : mpend);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        checks++;
        if (vol !== exp_vol || vol_req !== mpend) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t vol=%h vol_req=%b expected vol=%h vol_req=%b",
                     $time, vol, vol_req, exp_vol, mpend);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Pins DUT outputs and the model's own level to hand-computed values.
    task automatic chk_state(input string name, input logic [15:0] v, input logic r);
        chk({name, "_vol"}, vol, v);
        chk({name, "_req"}, {15'h0, vol_req}, {15'h0, r});
        chk({name, "_model"}, exp_vol, v);
    endtask

    task automatic press(input logic up, input logic dn, input int n);
        btn_up   = up;
        btn_down = dn;
        cyc(n);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(12);
    endtask

    task automatic ack_pulse();
        vol_ack = 1'b1;
        cyc(1);
        vol_ack = 1'b0;
        cyc(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        #2 RSTn = 1'b0;
        cyc(1);
        chk_state("in_reset", 16'h4040, 1'b1);
        cyc(2);
        RSTn = 1'b1;
        cyc(3);
        chk_state("pend_after_reset", 16'h4040, 1'b1);
        ack_pulse();
        chk_state("after_ack", 16'h4040, 1'b0);
        ack_pulse();
        chk_state("ack_in_idle", 16'h4040, 1'b0);

        // 3-cycle glitch must not pass the 4-cycle debounce
        btn_down = 1'b1;
        cyc(3);
        btn_down = 1'b0;
        cyc(12);
        chk_state("glitch", 16'h4040, 1'b0);

        press(1'b0, 1'b1, 10);
        chk_state("down_10", 16'h5050, 1'b1);
        ack_pulse();
        chk_state("down_10_ack", 16'h5050, 1'b0);

        press(1'b1, 1'b0, 10);
        ack_pulse();
        chk_state("back_to_4", 16'h4040, 1'b0);

        // 28 cycles held: steps at press, +20, +25
        press(1'b0, 1'b1, 28);
        chk_state("repeat", 16'h7070, 1'b1);

        // up step landing in the same cycle as an ack
        btn_up = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_fu) begin
                found   = 1'b1;
                vol_ack = 1'b1;
                btn_up  = 1'b0;
                cyc(1);
                vol_ack = 1'b0;
            end else begin
                cyc(1);
            end
        end
        btn_up = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL step_ack_timeout got=no_step expected=step_within_40");
        end
        cyc(12);
        chk_state("step_with_ack", 16'h6060, 1'b1);
        ack_pulse();
        chk_state("step_with_ack_2nd", 16'h6060, 1'b0);

        // saturation at 0
        press(1'b1, 1'b0, 60);
        ack_pulse();
        chk_state("to_zero", 16'h0000, 1'b0);
        press(1'b1, 1'b0, 10);
        chk_state("sat_low", 16'h0000, 1'b0);

        // saturation at 15
        press(1'b0, 1'b1, 120);
        ack_pulse();
        chk_state("to_max", 16'hF0F0, 1'b0);
        press(1'b0, 1'b1, 10);
        chk_state("sat_high", 16'hF0F0, 1'b0);

        // both held, then reset mid-hold
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cyc(40);
        chk_state("both_held", 16'hF0F0, 1'b0);
        #2 RSTn = 1'b0;
        cyc(2);
        chk_state("reset_mid_hold", 16'h4040, 1'b1);
        RSTn = 1'b1;
        cyc(40);
        chk_state("both_after_reset", 16'h4040, 1'b1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(12);
        ack_pulse();
        chk_state("final", 16'h4040, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
